// File: rtl/ram_readback_module_pkg.sv
// Shared definitions for the RAM readback controller: FSM encoding,
// read-latency limits and sweep-depth derivation.
package ram_readback_module_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_CLEAR = 3'd4;

  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 3;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/ram_readback_module_rd_tag_pipe.sv
// {valid, addr} delay line used to line up issued read addresses with the
// registered memory data. A synchronous flush empties it on abort.
module rd_tag_pipe #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr
);

  logic [STAGES-1:0]             r_valid;
  logic [STAGES-1:0][ADDR_W-1:0] r_addr;

  // Shift a new tag in every cycle; flush clears every stage at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_addr  <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
      r_addr  <= '0;
    end else begin
      r_valid <= {r_valid[STAGES-2:0], i_valid};
      r_addr  <= {r_addr[STAGES-2:0], i_addr};
    end
  end

  assign o_valid = r_valid[STAGES-1];
  assign o_addr  = r_addr[STAGES-1];

endmodule

// File: rtl/ram_readback_module.sv
// Sweeps all addresses of a ROM/RAM pair, streams the RAM words out with
// address tags and counts words where RAM differs from ROM.
module ram_readback_module
  import ram_readback_module_pkg::*;
#(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_sig,
  output logic              done_sig,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic [DATA_W-1:0] ram_data,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] data_addr,
  output logic              data_valid,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              err_flag
);

  localparam int unsigned       DEPTH     = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
    $error("READ_LAT out of supported range");
  end

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_done;
  logic [DATA_W-1:0] r_data_out;
  logic [ADDR_W-1:0] r_data_addr;
  logic              r_data_valid;
  logic [ADDR_W:0]   r_err_cnt;
  logic [ADDR_W-1:0] r_first_err_addr;
  logic              r_err_flag;

  logic              w_start;
  logic              w_flush;
  logic              w_push_valid;
  logic [ADDR_W-1:0] w_push_addr;
  logic              w_tag_valid;
  logic [ADDR_W-1:0] w_tag_addr;

  // Decide which tag enters the pipe this cycle and whether a pass starts or aborts.
  always_comb begin
    w_start      = 1'b0;
    w_flush      = 1'b0;
    w_push_valid = 1'b0;
    w_push_addr  = '0;
    case (r_state)
      ST_IDLE: begin
        if (start_sig) begin
          w_start      = 1'b1;
          w_push_valid = 1'b1;
        end
      end
      ST_READ: begin
        if (!start_sig) begin
          w_flush = 1'b1;
        end else if (r_rd_addr != LAST_ADDR) begin
          w_push_valid = 1'b1;
          w_push_addr  = r_rd_addr + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!start_sig) w_flush = 1'b1;
      end
      default: ;
    endcase
  end

  rd_tag_pipe #(
    .ADDR_W (ADDR_W),
    .STAGES (READ_LAT + 1)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_valid (w_push_valid),
    .i_addr  (w_push_addr),
    .o_valid (w_tag_valid),
    .o_addr  (w_tag_addr)
  );

  // Sequence the sweep; DONE is entered the cycle after the last word is presented,
  // so done_sig is high exactly while in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rd_addr <= '0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start_sig) begin
            r_rd_addr <= '0;
            r_state   <= ST_READ;
          end
        end
        ST_READ: begin
          if (!start_sig)                r_state   <= ST_IDLE;
          else if (r_rd_addr == LAST_ADDR) r_state <= ST_DRAIN;
          else                           r_rd_addr <= r_rd_addr + 1'b1;
        end
        ST_DRAIN: begin
          if (!start_sig) begin
            r_state <= ST_IDLE;
          end else if (r_data_valid && r_data_addr == LAST_ADDR) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_CLEAR;
        end
        ST_CLEAR: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Register emerging RAM words with their tags and accumulate ROM/RAM mismatches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_out       <= '0;
      r_data_addr      <= '0;
      r_data_valid     <= 1'b0;
      r_err_cnt        <= '0;
      r_first_err_addr <= '0;
      r_err_flag       <= 1'b0;
    end else begin
      r_data_valid <= w_tag_valid && !w_flush;
      if (w_tag_valid && !w_flush) begin
        r_data_out  <= ram_data;
        r_data_addr <= w_tag_addr;
      end
      if (w_start) begin
        r_err_cnt        <= '0;
        r_first_err_addr <= '0;
        r_err_flag       <= 1'b0;
      end else if (w_tag_valid && !w_flush && ram_data != rom_data) begin
        r_err_cnt <= r_err_cnt + 1'b1;
        if (!r_err_flag) begin
          r_first_err_addr <= w_tag_addr;
          r_err_flag       <= 1'b1;
        end
      end
    end
  end

  assign done_sig       = r_done;
  assign rd_addr        = r_rd_addr;
  assign data_out       = r_data_out;
  assign data_addr      = r_data_addr;
  assign data_valid     = r_data_valid;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err_addr;
  assign err_flag       = r_err_flag;

endmodule

// File: tb/tb_ram_readback_module.sv
// Directed bench for ram_readback_module: one READ_LAT=1 instance and one
// READ_LAT=3 instance, each fed by a behavioural ROM/RAM with matching latency.
module tb_ram_readback_module;

  logic clk;
  logic rst_n;
  logic start0, start1;

  logic [7:0] rom  [16];
  logic [7:0] ram0 [16];
  logic [7:0] ram1 [16];

  logic       d0_done, d0_dv, d0_eflag;
  logic [3:0] d0_rd, d0_da, d0_fea;
  logic [7:0] d0_dout, rom_q0, ram_q0;
  logic [4:0] d0_ecnt;

  logic       d1_done, d1_dv, d1_eflag;
  logic [3:0] d1_rd, d1_da, d1_fea;
  logic [7:0] d1_dout, rom_q1, ram_q1;
  logic [4:0] d1_ecnt;
  logic [3:0] a1, a2;

  int checks   = 0;
  int failures = 0;

  int n_valid, first_v, last_v, order_err, data_err;
  int n_done, first_done, last_done;
  logic [7:0] word5;
  int rd_at [64];
  int ec_at [64];
  int ef_at [64];

  ram_readback_module #(.ADDR_W(4), .DATA_W(8), .READ_LAT(1)) u_dut0 (
    .clk (clk), .rst_n (rst_n), .start_sig (start0), .done_sig (d0_done),
    .rd_addr (d0_rd), .rom_data (rom_q0), .ram_data (ram_q0),
    .data_out (d0_dout), .data_addr (d0_da), .data_valid (d0_dv),
    .err_cnt (d0_ecnt), .first_err_addr (d0_fea), .err_flag (d0_eflag)
  );

  ram_readback_module #(.ADDR_W(4), .DATA_W(8), .READ_LAT(3)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .start_sig (start1), .done_sig (d1_done),
    .rd_addr (d1_rd), .rom_data (rom_q1), .ram_data (ram_q1),
    .data_out (d1_dout), .data_addr (d1_da), .data_valid (d1_dv),
    .err_cnt (d1_ecnt), .first_err_addr (d1_fea), .err_flag (d1_eflag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle memories for the first instance.
  always @(posedge clk) begin
    rom_q0 <= rom[d0_rd];
    ram_q0 <= ram0[d0_rd];
  end

  // Three-cycle memories for the second instance.
  always @(posedge clk) begin
    a1     <= d1_rd;
    a2     <= a1;
    rom_q1 <= rom[a2];
    ram_q1 <= ram1[a2];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Raise start before edge 0, observe max_edges edges, drop start on the
  // stop_done-th done pulse or after edge drop_after.
  task automatic run_pass(input int sel, input int drop_after, input int stop_done,
                          input int max_edges);
    logic       dv, done;
    logic [3:0] da;
    logic [7:0] dout, expw;
    n_valid = 0; first_v = -1; last_v = -1; order_err = 0; data_err = 0;
    n_done = 0; first_done = -1; last_done = -1; word5 = '0;
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    for (int e = 0; e < max_edges; e++) begin
      @(posedge clk); #1;
      dv   = (sel == 0) ? d0_dv   : d1_dv;
      da   = (sel == 0) ? d0_da   : d1_da;
      dout = (sel == 0) ? d0_dout : d1_dout;
      done = (sel == 0) ? d0_done : d1_done;
      rd_at[e] = (sel == 0) ? int'(d0_rd)    : int'(d1_rd);
      ec_at[e] = (sel == 0) ? int'(d0_ecnt)  : int'(d1_ecnt);
      ef_at[e] = (sel == 0) ? int'(d0_eflag) : int'(d1_eflag);
      if (dv) begin
        if (first_v < 0) first_v = e;
        last_v = e;
        if (int'(da) != n_valid % 16) order_err++;
        expw = (sel == 0) ? ram0[da] : ram1[da];
        if (dout != expw) data_err++;
        if (da == 4'd5) word5 = dout;
        n_valid++;
      end
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = e;
        last_done = e;
        if (n_done >= stop_done) begin start0 = 1'b0; start1 = 1'b0; end
      end
      if (e == drop_after) begin start0 = 1'b0; start1 = 1'b0; end
    end
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rom[i]  = 8'(i * 3);
      ram0[i] = 8'(i * 3);
      ram1[i] = 8'(i * 3);
    end

    repeat (2) @(posedge clk); #1;
    check("rst_done",   d0_done,  0);
    check("rst_rdaddr", d0_rd,    0);
    check("rst_dv",     d0_dv,    0);
    check("rst_dout",   d0_dout,  0);
    check("rst_ecnt",   d0_ecnt,  0);
    check("rst_eflag",  d0_eflag, 0);
    check("rst_fea",    d0_fea,   0);
    check("rst1_dv",    d1_dv,    0);
    check("rst1_done",  d1_done,  0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean image, single pass.
    run_pass(0, -1, 1, 24);
    check("A_nvalid", n_valid, 16);
    check("A_first",  first_v, 2);
    check("A_last",   last_v, 17);
    check("A_order",  order_err, 0);
    check("A_data",   data_err, 0);
    check("A_ndone",  n_done, 1);
    check("A_doneat", first_done, 18);
    check("A_rd5",    rd_at[5], 5);
    check("A_rdhold", rd_at[17], 15);
    check("A_ecnt",   d0_ecnt, 0);
    check("A_eflag",  d0_eflag, 0);

    // Words 5 and 11 corrupted.
    ram0[5]  = ram0[5]  ^ 8'hFF;
    ram0[11] = ram0[11] ^ 8'hFF;
    run_pass(0, -1, 1, 24);
    check("B_nvalid", n_valid, 16);
    check("B_data",   data_err, 0);
    check("B_word5",  word5, 8'hF0);
    check("B_ef6",    ef_at[6], 0);
    check("B_ef7",    ef_at[7], 1);
    check("B_ec12",   ec_at[12], 1);
    check("B_ecnt",   d0_ecnt, 2);
    check("B_fea",    d0_fea, 5);
    check("B_eflag",  d0_eflag, 1);
    check("B_ndone",  n_done, 1);

    // Abort after edge 7, then a clean restart.
    run_pass(0, 7, 1, 20);
    check("C_nvalid", n_valid, 6);
    check("C_last",   last_v, 7);
    check("C_ndone",  n_done, 0);
    check("C_ecnt",   d0_ecnt, 1);
    check("C_eflag",  d0_eflag, 1);
    check("C_fea",    d0_fea, 5);
    ram0[5]  = ram0[5]  ^ 8'hFF;
    ram0[11] = ram0[11] ^ 8'hFF;
    run_pass(0, -1, 1, 24);
    check("C2_ec0",    ec_at[0], 0);
    check("C2_ef0",    ef_at[0], 0);
    check("C2_first",  first_v, 2);
    check("C2_nvalid", n_valid, 16);
    check("C2_ndone",  n_done, 1);
    check("C2_ecnt",   d0_ecnt, 0);

    // Back-to-back passes with word 3 corrupted.
    ram0[3] = ram0[3] ^ 8'hFF;
    run_pass(0, -1, 2, 44);
    check("D_ndone",  n_done, 2);
    check("D_done1",  first_done, 18);
    check("D_done2",  last_done, 39);
    check("D_nvalid", n_valid, 32);
    check("D_order",  order_err, 0);
    check("D_ec20",   ec_at[20], 1);
    check("D_ec21",   ec_at[21], 0);
    check("D_rd22",   rd_at[22], 1);
    check("D_ecnt",   d0_ecnt, 1);
    check("D_fea",    d0_fea, 3);

    // Asynchronous reset in the middle of READ.
    start0 = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("E_pre_ecnt", d0_ecnt, 1);
    check("E_pre_dv",   d0_dv, 1);
    #2 rst_n = 1'b0;
    #1;
    check("E_rdaddr", d0_rd, 0);
    check("E_dv",     d0_dv, 0);
    check("E_ecnt",   d0_ecnt, 0);
    check("E_eflag",  d0_eflag, 0);
    check("E_fea",    d0_fea, 0);
    check("E_daddr",  d0_da, 0);
    check("E_dout",   d0_dout, 0);
    check("E_done",   d0_done, 0);
    start0 = 1'b0;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    ram0[3] = ram0[3] ^ 8'hFF;
    run_pass(0, -1, 1, 24);
    check("E2_nvalid", n_valid, 16);
    check("E2_ndone",  n_done, 1);
    check("E2_doneat", first_done, 18);
    check("E2_ecnt",   d0_ecnt, 0);

    // Three-cycle latency instance.
    run_pass(1, -1, 1, 26);
    check("F_first",  first_v, 4);
    check("F_last",   last_v, 19);
    check("F_nvalid", n_valid, 16);
    check("F_order",  order_err, 0);
    check("F_data",   data_err, 0);
    check("F_ndone",  n_done, 1);
    check("F_doneat", first_done, 20);
    check("F_ecnt",   d1_ecnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_readback_module.md
Name: ram_readback_module

Overview:
- Read-side counterpart to the ROM-to-RAM copy controller.
- On start_sig it sweeps addresses 0..DEPTH-1 to both the source ROM and the destination RAM.
- It aligns their registered read data using a latency-matched tag pipeline, streams the RAM contents out with address tags, and counts ROM/RAM mismatches.
- Signals completion with a one-cycle done_sig pulse, using the same start/done handshake as the copy controller.

Parameters:
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries swept.
- DATA_W, 8, ROM/RAM data width.
- READ_LAT, 1, memory read latency in clocks, range 1..3. Data for an address registered at edge N is valid at the memory output after edge N+READ_LAT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_sig  in  1  level request from the master; held high for the whole pass.
- done_sig  out  1  one-cycle completion pulse.
- rd_addr  out  ADDR_W  registered read address, shared by ROM and RAM.
- rom_data  in  DATA_W  ROM read data (expected value).
- ram_data  in  DATA_W  RAM read data (actual value).
- data_out  out  DATA_W  registered RAM word.
- data_addr  out  ADDR_W  address tag for data_out.
- data_valid  out  1  data_out/data_addr qualifier, one cycle per word.
- err_cnt  out  ADDR_W+1  mismatch count for the current/last pass.
- first_err_addr  out  ADDR_W  address of the first mismatch in the pass.
- err_flag  out  1  high once any mismatch has been seen in the pass.

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, tag pipeline is cleared.
- FSM states: IDLE, READ, DRAIN, DONE, CLEAR.
- IDLE:
  - Entered with start_sig=1: rd_addr<=0, issue tag {valid=1, addr=0}, clear err_cnt/err_flag/first_err_addr, go to READ.
  - With start_sig=0: hold.
- READ:
  - Each edge: rd_addr<=rd_addr+1 and a tag is pushed for the new address.
  - When rd_addr==DEPTH-1, push an invalid tag and go to DRAIN; rd_addr holds at DEPTH-1.
  - No wrap-around occurs inside a pass.
- Tag pipeline:
  - Shift register of depth READ_LAT+1 carrying {valid, addr}.
  - A tag issued with the address at edge N emerges at edge N+READ_LAT+1.
  - At that edge: data_out<=ram_data, data_addr<=tag.addr, data_valid<=tag.valid.
- Compare: on each emerging valid tag, if ram_data!=rom_data:
  - err_cnt<=err_cnt+1.
  - If err_flag==0: first_err_addr<=tag.addr and err_flag<=1.
  - err_cnt cannot overflow (max DEPTH fits in ADDR_W+1 bits).
- DRAIN: push invalid tags until the tag for address DEPTH-1 has emerged, then go to DONE.
- DONE: done_sig<=1 for exactly one cycle, go to CLEAR.
- CLEAR: done_sig<=0, go to IDLE.
- Results: err_cnt, err_flag and first_err_addr hold until the next pass starts.
- Handshake:
  - The master drops start_sig after sampling done_sig.
  - If start_sig is still high in IDLE, a new pass starts immediately (legal back-to-back operation).
- Timing, READ_LAT=1, DEPTH=16, start seen at edge 0:
  - Address k is issued at edge k.
  - data_valid for word k is high after edge k+2.
  - Last word is valid after edge 17.
  - done_sig is high after edge 18.
  - Back in IDLE after edge 20.
- Abort: start_sig low in READ or DRAIN:
  - Go to IDLE at the next edge and clear the tag pipeline; no further data_valid.
  - No done_sig; err outputs keep their partial values.
- start_sig low in DONE or CLEAR: ignored; the pulse completes.
- Reset mid-pass: asynchronous return to reset values; no done_sig.

Decomposition:
- Shared package: FSM state encoding (3-bit), READ_LAT range limits, DEPTH derivation.
- Sub-module rd_tag_pipe:
  - Parameterised {valid, addr} delay line of depth READ_LAT+1, with synchronous flush input for abort.
  - Reused later by the write-side controller for latency alignment.

Test Plan:
- RAM preloaded equal to ROM (data=addr*3), READ_LAT=1, start held until done -> 16 data_valid pulses after edges 2..17 with data_addr 0..15 in order; data_out=addr*3; done_sig single pulse after edge 18; err_cnt=0, err_flag=0.
- RAM words 5 and 11 corrupted (XOR 8'hFF) -> err_cnt=2, first_err_addr=5, err_flag=1 after done; data_out at addr 5 shows the corrupted value.
- READ_LAT=3 build, all-match image -> first data_valid after edge 4, last after edge 19, done_sig after edge 20; no gaps or duplicates.
- start_sig dropped after edge 7 -> no data_valid after the pipeline flush, no done_sig, FSM idle; restart -> full clean pass with err fields cleared at start.
- start_sig held high through done -> second pass begins immediately after CLEAR; done_sig pulses twice; err_cnt resets at the second pass start.
- rst_n asserted asynchronously mid-READ -> all outputs 0 immediately, rd_addr=0, no done_sig; normal pass after release.
